mmio_console: RTL and testbench
===============================

# mmio_console

Memory-mapped console transmitter on the processor's data-store bus. It responds to the `memwrite`/`dataadr`/`writedata` store interface that the core drives toward data memory.
- Stores to its TXDATA register queue bytes in an internal FIFO.
- A serial engine drains the FIFO onto a UART-format line (`txd`).
- A store to HALT requests simulation end, granted once the FIFO has drained.
- Loads return live status.

It sits beside `dmem` in `top`, selected by the top-level address decode.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO entries; must be a power of two, ≤ 128.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset on the next rising edge).
- `sel` in 1: device select from the top-level address decode.
- `memwrite` in 1: store strobe, qualified by `sel`.
- `dataadr` in 32: byte address; only `dataadr[3:2]` are decoded.
- `writedata` in 32: store data.
- `readdata` out 32: combinational load data.
- `txd` out 1: serial output, idles high.
- `halt` out 1: sticky end-of-run indication.

## Operation
- **Register map** (by `dataadr[3:2]`). Every write requires `sel & memwrite` at a rising edge.
  - 0 TXDATA: a write pushes `writedata[7:0]`.
  - 1 HALT: a write sets `halt_req`; the data is ignored.
  - 2 STATUS: a write clears `overflow`; the data is ignored.
  - 3: reserved; writes are ignored.
- **STATUS read value:**
  - bit0 `busy` (FSM not IDLE)
  - bit1 `empty`
  - bit2 `full`
  - bit3 `overflow`
  - bit4 `halt_req`
  - bits[15:8] `count`
  - all other bits 0
- **Other reads:** reads of addresses 0, 1 and 3 return 0. `readdata` is 0 when `sel` is low.
- **FIFO:**
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth.
  - `count` ranges 0..FIFO_DEPTH.
  - A push while full with no same-edge pop is dropped and sets `overflow` (sticky).
  - A push and a pop on the same edge are both performed; `count` is unchanged. This holds even when full.
- **FSM:** IDLE → START → DATA → STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty at an edge: pop the head into the shifter, clear the bit counter, go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `txd`=shifter[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After 8 bits (LSB first), go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. On the final cycle: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - The baud counter runs 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary.
- **Halt:**
  - `halt` = registered (`halt_req` & `empty` & IDLE). It rises on the edge after the last stop bit completes and stays high until reset.
  - TXDATA writes after `halt_req` are still accepted and transmitted; `halt` waits for them.
- **Reset:** on reset (including mid-frame), the next edge clears:
  - FIFO pointers and `count`
  - `overflow`, `halt_req`, `halt`
  - FSM (to IDLE)

  Any partially sent byte is abandoned.

## Timing
- Reset values: `txd`=1, `halt`=0. `readdata` shows STATUS = 0x00000002 (empty) when selected.
- Push latency: a TXDATA write at edge N with the FSM idle and FIFO empty gives `count`=1 after N. The pop occurs at N+1, and `txd` falls after N+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- `txd` is a registered output with no combinational path from bus inputs. `readdata` is combinational from `sel`, `dataadr` and registered state.
- STATUS reflects state after the most recent edge. A read in the same cycle as a write sees pre-write values.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, write 0x55 to addr 0 at edge 0 → `txd`=0 for cycles 1–4, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; `busy` drops after cycle 40.
- **Back-to-back frames:** write 0xA5 and 0x0F on consecutive edges → two contiguous 40-cycle frames with no idle cycle; STATUS `count` reads 1 during the first frame.
- **Overflow:** FIFO_DEPTH=8, 10 consecutive TXDATA writes 0x00..0x09 → `full` set, `overflow`=1, exactly 0x00..0x08 transmitted; a STATUS write clears `overflow`.
- **Halt drain:** queue 0x31, 0x32, then write HALT → `halt_req`=1 immediately; `halt` stays 0 until the edge after the second stop bit, then 1 permanently.
- **Reset mid-frame:** assert `reset`=0 for one edge during DATA bit 3 → `txd`=1 next cycle, STATUS=0x00000002, no further frames.
- **Decode:** with `sel`=0, a write to addr 0 leaves `count`=0 and `readdata`=0. A reserved write (addr 0xC) changes nothing.

Source files
------------

// File: rtl/mmio_console.sv
// Memory-mapped console transmitter: bus stores fill a byte FIFO that is drained
// onto an 8N1 UART line; a HALT store raises a sticky halt once the line is quiet.
module mmio_console #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        txd,
   output logic        halt
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_reg, state_next;
   logic [BW-1:0]   baud_reg, baud_next;
   logic [2:0]      bit_reg, bit_next;
   logic [7:0]      shift_reg, shift_next;
   logic            txd_reg, txd_next;
   logic            pop;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic            overflow_reg, halt_req_reg, halt_reg;

   logic            wr_en, push, push_ok, empty, full, baud_end;
   logic [7:0]      head;
   logic            unused_bits;

   assign wr_en    = sel & memwrite;
   assign push     = wr_en && (dataadr[3:2] == 2'd0);
   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CW'(FIFO_DEPTH));
   // A full FIFO still accepts a byte when the engine pops on the same edge.
   assign push_ok  = push && (!full || pop);
   assign head     = mem[rd_ptr_reg];
   assign baud_end = (baud_reg == BW'(CLKS_PER_BIT - 1));
   assign unused_bits = ^{dataadr[31:4], dataadr[1:0], writedata[31:8]};

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_next = head;
               bit_next   = '0;
               baud_next  = '0;
               state_next = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_next  = '0;
               state_next = DATA;
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_next  = '0;
               shift_next = shift_reg >> 1;
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) state_next = STOP;
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_next = '0;
               // Chain straight into the next start bit so frames stay contiguous.
               if (!empty) begin
                  pop        = 1'b1;
                  shift_next = head;
                  bit_next   = '0;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_reg + BW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      case (state_next)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
         default: txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         baud_reg     <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         txd_reg      <= 1'b1;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         halt_req_reg <= 1'b0;
         halt_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         txd_reg   <= txd_next;
         if (push_ok)
            wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
         if (push_ok && !pop)
            count_reg <= count_reg + CW'(1);
         else if (!push_ok && pop)
            count_reg <= count_reg - CW'(1);
         if (push && full && !pop)
            overflow_reg <= 1'b1;
         else if (wr_en && dataadr[3:2] == 2'd2)
            overflow_reg <= 1'b0;
         if (wr_en && dataadr[3:2] == 2'd1)
            halt_req_reg <= 1'b1;
         halt_reg <= halt_reg | (halt_req_reg & empty & (state_reg == IDLE));
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= writedata[7:0];
   end

   always_comb begin
      readdata = '0;
      if (sel && dataadr[3:2] == 2'd2) begin
         readdata[0]    = (state_reg != IDLE);
         readdata[1]    = empty;
         readdata[2]    = full;
         readdata[3]    = overflow_reg;
         readdata[4]    = halt_req_reg;
         readdata[15:8] = 8'(count_reg);
      end
   end

   assign txd  = txd_reg;
   assign halt = halt_reg;
endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: directed scenarios plus random bus traffic, every cycle
// compared against a frame-level model of the FIFO, serial line and status word.
module tb_mmio_console;
   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int LAST  = 10 * CPB - 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sel = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        txd;
   logic        halt;

   int n_checks = 0;
   int n_errors = 0;

   // Model: pending bytes, position within the frame on the line (-1 = idle).
   logic [7:0] q[$];
   logic [7:0] cur = '0;
   int         pos = -1;
   bit         ovf = 0, hreq = 0, halt_e = 0;

   mmio_console #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .sel(sel), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .readdata(readdata),
      .txd(txd), .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_txd();
      int b;
      if (pos < 0) return 1'b1;
      b = pos / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return cur[b-1];
   endfunction

   function automatic logic [31:0] exp_rd(input logic s, input logic [31:0] a);
      logic [31:0] st;
      if (!s || a[3:2] != 2'd2) return 32'h0;
      st = 32'h0;
      st[0] = (pos >= 0);
      st[1] = (q.size() == 0);
      st[2] = (q.size() == DEPTH);
      st[3] = ovf;
      st[4] = hreq;
      st[15:8] = 8'(q.size());
      return st;
   endfunction

   task automatic model_edge(input logic s, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic r);
      bit pop_now, push_now;
      if (!r) begin
         q.delete();
         pos = -1; ovf = 0; hreq = 0; halt_e = 0;
         return;
      end
      pop_now  = (q.size() > 0) && (pos < 0 || pos == LAST);
      push_now = 0;
      if (hreq && q.size() == 0 && pos < 0) halt_e = 1;
      if (s && w) begin
         case (a[3:2])
            2'd0: if (q.size() < DEPTH || pop_now) push_now = 1; else ovf = 1;
            2'd1: hreq = 1;
            2'd2: ovf = 0;
            default: ;
         endcase
      end
      if (pos >= 0 && pos < LAST) pos++;
      else if (pop_now) begin
         cur = q.pop_front();
         pos = 0;
      end else pos = -1;
      if (push_now) q.push_back(d[7:0]);
   endtask

   task automatic step(input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
      @(negedge clk);
      sel = s; memwrite = w; dataadr = a; writedata = d; reset = r;
      #1;
      check("txd", 32'(txd), 32'(exp_txd()));
      check("halt", 32'(halt), 32'(halt_e));
      check("readdata", readdata, exp_rd(s, a));
      @(posedge clk);
      if (s && w && r) $display("write adr=%h data=%h", a, d);
      model_edge(s, w, a, d, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      step(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      idle(3);

      // Single byte
      step(1'b1, 1'b1, 32'h0, 32'h55, 1'b1);
      idle(45);
      // Back-to-back frames
      step(1'b1, 1'b1, 32'h0, 32'hA5, 1'b1);
      step(1'b1, 1'b1, 32'h0, 32'h0F, 1'b1);
      idle(90);
      // Overflow burst, then clear
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h0, 32'(i), 1'b1);
      idle(5);
      step(1'b1, 1'b1, 32'h8, 32'hFFFF, 1'b1);
      idle(380);
      // Halt drain
      step(1'b1, 1'b1, 32'h0, 32'h31, 1'b1);
      step(1'b1, 1'b1, 32'h0, 32'h32, 1'b1);
      step(1'b1, 1'b1, 32'h4, 32'h0, 1'b1);
      idle(100);
      step(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      // Reset during data bit 3
      step(1'b1, 1'b1, 32'h0, 32'hC3, 1'b1);
      step(1'b1, 1'b1, 32'h0, 32'h7E, 1'b1);
      idle(16);
      step(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      idle(60);
      // Decode: deselected and reserved writes
      step(1'b0, 1'b1, 32'h0, 32'h41, 1'b1);
      step(1'b0, 1'b0, 32'h8, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'hC, 32'h42, 1'b1);
      idle(4);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         int          r;
         logic        rn;
         logic [31:0] a, d;
         r  = $urandom_range(0, 99);
         rn = ($urandom_range(0, 499) != 0);
         d  = $urandom;
         a  = {$urandom} & 32'hFFFF_FFFC;
         if (r < 7)        step(1'b1, 1'b1, a & ~32'hC, d, rn);
         else if (r == 7)  step(1'b1, 1'b1, (a & ~32'hC) | 32'h4, d, rn);
         else if (r == 8)  step(1'b1, 1'b1, (a & ~32'hC) | 32'h8, d, rn);
         else if (r == 9)  step(1'b1, 1'b1, a | 32'hC, d, rn);
         else if (r == 10) step(1'b0, 1'b1, a, d, rn);
         else              step($urandom_range(0, 3) != 0, 1'b0, a, d, rn);
      end
      idle(400);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
